// File: rtl/sync_bus_qualifier.sv
// sync_bus_qualifier
// Brings a multi-bit bus from an asynchronous source into the clk_i domain
// through a two-flop synchronizer. A new value is accepted only after it
// has been seen unchanged at the synchronizer output for STABLE_CYCLES
// consecutive samples. Accepted updates and rejected (unstable)
// transitions are counted with saturating counters.
//
// Parameters:
//   WIDTH         bus width in bits
//   STABLE_CYCLES identical synchronized samples needed to accept (2..255)
//   CNT_W         width of the update and glitch counters
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active-high
//   sig_i        asynchronous bus input
//   enable_i     qualification enable
//   clr_cnt_i    synchronous clear of both counters (wins over an increment)
//   data_o       last accepted value
//   valid_o      one-cycle pulse in the cycle data_o updates
//   busy_o       high while a candidate value is being qualified
//   upd_cnt_o    accepted updates, saturating
//   glitch_cnt_o rejected transitions, saturating
module sync_bus_qualifier #(
    parameter int WIDTH         = 32,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] sig_i,
    input  logic             enable_i,
    input  logic             clr_cnt_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] upd_cnt_o,
    output logic [CNT_W-1:0] glitch_cnt_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    // stab_cnt counts samples already matching the candidate, so the
    // commit fires when the sample that would make it STABLE_CYCLES arrives.
    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] s1_r;
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] s_r;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] cand_r;
    logic [WIDTH-1:0] cand_s;
    logic [7:0]       stab_cnt_r;
    logic [7:0]       stab_cnt_s;
    logic [WIDTH-1:0] data_r;
    logic             valid_r;
    logic             busy_r;
    logic [CNT_W-1:0] upd_cnt_r;
    logic [CNT_W-1:0] glitch_cnt_r;
    logic             commit_s;
    logic             glitch_s;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Two-flop synchronizer; keeps running regardless of enable_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_r <= {WIDTH{1'b0}};
            s_r  <= {WIDTH{1'b0}};
        end else begin
            s1_r <= sig_i;
            s_r  <= s1_r;
        end
    end

    // Next-state logic for the qualification FSM, priority ordered in CHECK.
    always_comb begin
        state_s    = state_r;
        cand_s     = cand_r;
        stab_cnt_s = stab_cnt_r;
        commit_s   = 1'b0;
        glitch_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable_i && (s_r != data_r)) begin
                    state_s    = ST_CHECK;
                    cand_s     = s_r;
                    stab_cnt_s = 8'd1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (!enable_i) begin
                    state_s = ST_IDLE;
                end else if ((s_r == cand_r) && (stab_cnt_r == STAB_LAST)) begin
                    commit_s = 1'b1;
                    state_s  = ST_IDLE;
                end else if (s_r == cand_r) begin
                    stab_cnt_s = stab_cnt_r + 8'd1;
                end else if (s_r == data_r) begin
                    // Bus fell back to the value already accepted.
                    glitch_s = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    // Bus moved on to yet another value: restart on it.
                    glitch_s   = 1'b1;
                    cand_s     = s_r;
                    stab_cnt_s = 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, candidate tracking and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            cand_r     <= {WIDTH{1'b0}};
            stab_cnt_r <= 8'd0;
            data_r     <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cand_r     <= cand_s;
            stab_cnt_r <= stab_cnt_s;
            valid_r    <= commit_s;
            busy_r     <= (state_s == ST_CHECK);
            if (commit_s) begin
                data_r <= cand_r;
            end else begin
                data_r <= data_r;
            end
        end
    end

    // Saturating event counters; a clear overrides a coincident increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            upd_cnt_r    <= {CNT_W{1'b0}};
            glitch_cnt_r <= {CNT_W{1'b0}};
        end else if (clr_cnt_i) begin
            upd_cnt_r    <= {CNT_W{1'b0}};
            glitch_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (commit_s) begin
                upd_cnt_r <= sat_inc(upd_cnt_r);
            end else begin
                upd_cnt_r <= upd_cnt_r;
            end
            if (glitch_s) begin
                glitch_cnt_r <= sat_inc(glitch_cnt_r);
            end else begin
                glitch_cnt_r <= glitch_cnt_r;
            end
        end
    end

    assign data_o       = data_r;
    assign valid_o      = valid_r;
    assign busy_o       = busy_r;
    assign upd_cnt_o    = upd_cnt_r;
    assign glitch_cnt_o = glitch_cnt_r;

endmodule

// File: tb/tb_sync_bus_qualifier.sv
// Testbench for sync_bus_qualifier. Two instances share the stimulus: the
// default configuration and one with 2-bit counters for saturation. The
// stimulus process pushes the expected response of each commit into a
// queue; a monitor pops and compares whenever valid_o pulses.
module tb_sync_bus_qualifier;

    logic        clk;
    logic        rst;
    logic [31:0] sig;
    logic        en;
    logic        clr;
    logic [31:0] data;
    logic        valid;
    logic        busy;
    logic [15:0] upd;
    logic [15:0] glitch;
    logic [31:0] data2;
    logic        valid2;
    logic        busy2;
    logic [1:0]  upd2;
    logic [1:0]  glitch2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0] data;
        logic [15:0] upd;
        logic [15:0] glitch;
        logic [1:0]  upd2;
        logic [1:0]  glitch2;
    } exp_t;

    exp_t exp_q[$];

    sync_bus_qualifier #(.WIDTH(32), .STABLE_CYCLES(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .sig_i(sig), .enable_i(en), .clr_cnt_i(clr),
        .data_o(data), .valid_o(valid), .busy_o(busy),
        .upd_cnt_o(upd), .glitch_cnt_o(glitch)
    );

    sync_bus_qualifier #(.WIDTH(32), .STABLE_CYCLES(4), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .sig_i(sig), .enable_i(en), .clr_cnt_i(clr),
        .data_o(data2), .valid_o(valid2), .busy_o(busy2),
        .upd_cnt_o(upd2), .glitch_cnt_o(glitch2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [15:0] u, input logic [15:0] g,
                        input logic [1:0] u2, input logic [1:0] g2);
        exp_t e;
        e.data = d; e.upd = u; e.glitch = g; e.upd2 = u2; e.glitch2 = g2;
        exp_q.push_back(e);
    endtask

    // Check busy/valid over n falling edges; bit i of each mask is the
    // expected value after the i-th following rising edge.
    task automatic run_expect(input string tag, input logic [15:0] bmask,
                              input logic [15:0] vmask, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 32'(bmask[i]));
            check({tag, "_valid"}, 32'(valid), 32'(vmask[i]));
        end
    endtask

    // Monitor: compare each commit against the queued expectation.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (valid || valid2) begin
            check("valid2_match", 32'(valid2), 32'(valid));
            if (prev_valid) begin
                check("valid_back_to_back", 32'(prev_valid), 32'(1'b0));
            end
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(valid), 32'(1'b0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_data", data, e.data);
                check("mon_data2", data2, e.data);
                check("mon_upd", 32'(upd), 32'(e.upd));
                check("mon_glitch", 32'(glitch), 32'(e.glitch));
                check("mon_upd2", 32'(upd2), 32'(e.upd2));
                check("mon_glitch2", 32'(glitch2), 32'(e.glitch2));
            end
        end
        prev_valid = valid;
    end

    initial begin
        rst = 1'b1; sig = 32'h0; en = 1'b1; clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data", data, 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_upd", 32'(upd), 32'h0);
        check("rst_glitch", 32'(glitch), 32'h0);

        // Clean step: busy after edges k+2..k+4, commit at k+5.
        sig = 32'hA5A5_A5A5;
        push(32'hA5A5_A5A5, 16'd1, 16'd0, 2'd1, 2'd0);
        run_expect("step", 16'h001C, 16'h0020, 7);
        check("step_data", data, 32'hA5A5_A5A5);
        check("step_upd", 32'(upd), 32'd1);
        check("step_glitch", 32'(glitch), 32'd0);

        // 0x1 for two samples then 0x3: one glitch, 0x3 committed at k+7.
        sig = 32'h1;
        push(32'h3, 16'd2, 16'd1, 2'd2, 2'd1);
        @(negedge clk);
        @(negedge clk);
        sig = 32'h3;
        run_expect("unstable", 16'h001F, 16'h0020, 8);
        check("unstable_glitch", 32'(glitch), 32'd1);
        check("unstable_data", data, 32'h3);

        // Establish 0x10, then a one-cycle excursion to 0x11.
        sig = 32'h10;
        push(32'h10, 16'd3, 16'd1, 2'd3, 2'd1);
        run_expect("step10", 16'h001C, 16'h0020, 7);
        sig = 32'h11;
        @(negedge clk);
        sig = 32'h10;
        run_expect("return", 16'h0002, 16'h0000, 6);
        check("return_glitch", 32'(glitch), 32'd2);
        check("return_data", data, 32'h10);
        check("return_upd", 32'(upd), 32'd3);

        // Enable drop at stab_cnt=2, then re-enable with the bus still different.
        sig = 32'h22;
        push(32'h22, 16'd4, 16'd2, 2'd3, 2'd2);
        run_expect("en_pre", 16'h000C, 16'h0000, 4);
        en = 1'b0;
        run_expect("en_off", 16'h0000, 16'h0000, 4);
        check("en_off_data", data, 32'h10);
        check("en_off_upd", 32'(upd), 32'd3);
        check("en_off_glitch", 32'(glitch), 32'd2);
        en = 1'b1;
        run_expect("en_on", 16'h0007, 16'h0008, 5);
        check("sat_upd2", 32'(upd2), 32'd3);

        // Clear coincident with a commit: counters zero, data still updated.
        sig = 32'h55;
        push(32'h55, 16'd0, 16'd0, 2'd0, 2'd0);
        run_expect("clr_pre", 16'h001C, 16'h0000, 5);
        clr = 1'b1;
        run_expect("clr_commit", 16'h0000, 16'h0001, 1);
        clr = 1'b0;
        check("clr_data", data, 32'h55);
        check("clr_upd", 32'(upd), 32'd0);
        check("clr_glitch", 32'(glitch), 32'd0);

        // Counting resumes from zero after the clear.
        sig = 32'h66;
        push(32'h66, 16'd1, 16'd0, 2'd1, 2'd0);
        run_expect("after_clr", 16'h001C, 16'h0020, 7);

        // Reset during CHECK aborts the candidate.
        sig = 32'h77;
        run_expect("mid_pre", 16'h0004, 16'h0000, 3);
        rst = 1'b1;
        sig = 32'h0;
        @(negedge clk);
        check("mid_rst_data", data, 32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_upd", 32'(upd), 32'h0);
        check("mid_rst_glitch", 32'(glitch), 32'h0);
        check("mid_rst_upd2", 32'(upd2), 32'h0);
        rst = 1'b0;
        run_expect("mid_post", 16'h0000, 16'h0000, 8);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sync_bus_qualifier.md
Name: sync_bus_qualifier

Overview:
- Controller for a two-stage flop synchronizer on a multi-bit bus driven from an asynchronous source, e.g. a status word from the device under radiation test into the checker Wishbone domain.
- Runs the synchronizer and accepts a new bus value only after it has been stable for a programmable number of cycles.
- Raises a one-cycle valid strobe on each accepted value.
- Keeps saturating counters of accepted updates and of rejected (unstable) transitions for the checker register map.

Parameters:
WIDTH, 32, bus width in bits
STABLE_CYCLES, 4, consecutive identical synchronized samples required to accept a value; legal range 2..255
CNT_W, 16, width of the update and glitch counters

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
sig_i  input  WIDTH  asynchronous bus input
enable_i  input  1  qualification enable (synchronous)
clr_cnt_i  input  1  synchronous clear of both counters
data_o  output  WIDTH  last accepted value
valid_o  output  1  one-cycle pulse when data_o updates
busy_o  output  1  high while in CHECK
upd_cnt_o  output  CNT_W  accepted updates, saturating
glitch_cnt_o  output  CNT_W  rejected transitions, saturating

Behaviour:
- Clock and reset: one clock, clk_i. Reset is rst_i, synchronous and active-high.
- Reset values: sync stages, candidate, data_o, stab_cnt, both counters all 0; valid_o 0; busy_o 0; state IDLE. Reset asserted mid-CHECK aborts with no commit and no count.
- Synchronizer: two ASYNC_REG flops, sig_i -> s1 -> s. Sampling edge k updates s1; s updates at edge k+1.
- Internal state: candidate register (WIDTH) and stab_cnt (8 bit).
- IDLE, busy_o=0:
  - if enable_i=1 and s != data_o: go to CHECK, candidate<=s, stab_cnt<=1.
  - otherwise hold.
- CHECK, busy_o=1, evaluated in this priority order each cycle:
  1. enable_i=0: go to IDLE, no counts change.
  2. s == candidate and stab_cnt == STABLE_CYCLES-1: commit. data_o<=candidate, valid_o=1 for exactly that one cycle, upd_cnt+1, go to IDLE.
  3. s == candidate: stab_cnt+1.
  4. s != candidate and s == data_o: glitch_cnt+1, go to IDLE (bus returned to the old value).
  5. s != candidate otherwise: glitch_cnt+1, candidate<=s, stab_cnt<=1, stay in CHECK.
- Latency: a clean step first sampled at edge k produces a commit at edge k+1+STABLE_CYCLES. With the default, data_o and valid_o update at edge k+5.
- After a commit, the next change can enter CHECK on the following cycle at the earliest.
- valid_o is never high in two consecutive cycles.
- Counters:
  - saturate at all-ones and do not wrap.
  - clr_cnt_i zeroes both counters. A clear in the same cycle as an increment wins: result 0.
  - clr_cnt_i does not affect the state machine or data_o.
- enable_i=0 in IDLE: the synchronizer keeps running, no detection. When enable_i rises while s != data_o, CHECK is entered on that cycle.
- data_o changes only on a commit or a reset.

Test Plan:
- Clean step: after reset, sig_i 0 -> 0xA5A5A5A5 held, first sampled at edge k. data_o=0xA5A5A5A5 and valid_o=1 at edge k+5 only; upd_cnt_o=1; glitch_cnt_o=0; busy_o high edges k+2..k+4.
- Unstable then settle: sig_i 0 -> 0x1 for 2 cycles -> 0x3 held. glitch_cnt_o=1; data_o=0x3 committed 4 stable samples after 0x3 reaches s; 0x1 never appears on data_o.
- Return to old value: data_o=0x10; sig_i pulses to 0x11 for 1 cycle. glitch_cnt_o increments by 1, state returns to IDLE, valid_o stays 0, data_o=0x10.
- Enable drop: enable_i cleared while stab_cnt=2 -> IDLE, no counts, data_o unchanged. Re-asserting enable_i with the bus still different -> CHECK restarts at stab_cnt=1; commit STABLE_CYCLES-1 cycles later.
- Saturation and clear: CNT_W=2, four clean updates -> upd_cnt_o=3, fourth valid_o still pulses. clr_cnt_i in the same cycle as a commit -> upd_cnt_o=0, data_o still updated.
- Reset mid-operation: rst_i asserted during CHECK -> next cycle all outputs 0, state IDLE, no valid_o pulse.
